// File: rtl/sb_tx_serializer.sv
// Sideband transmit serializer: shifts one framed phase out LSB first with a
// gated clock enable, then holds a mandatory clock-gated low gap before idling.
module sb_tx_serializer #(
  parameter int PHASE_W = 64,
  parameter int GAP_UI  = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [PHASE_W-1:0] i_packet_phase,
  input  logic               i_packet_valid,
  output logic               o_ser_data,
  output logic               o_clk_en,
  output logic               o_ser_done,
  output logic               o_overrun
);

  localparam int MAX_W = (PHASE_W > GAP_UI) ? PHASE_W : GAP_UI;
  localparam int CNT_W = $clog2(MAX_W) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PHASE_W - 1);
  localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'(GAP_UI - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [PHASE_W-1:0] r_shift, w_shift_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_data, w_data_nxt;
  logic               r_clk_en, w_clk_en_nxt;
  logic               r_done, w_done_nxt;
  logic               r_ovr, w_ovr_nxt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_data   <= 1'b0;
      r_clk_en <= 1'b0;
      r_done   <= 1'b1;
      r_ovr    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_cnt    <= w_cnt_nxt;
      r_data   <= w_data_nxt;
      r_clk_en <= w_clk_en_nxt;
      r_done   <= w_done_nxt;
      r_ovr    <= w_ovr_nxt;
    end
  end

  // Outputs are computed for the state being entered, so every output is a
  // flop and the first data bit appears on the load edge itself.
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_cnt_nxt    = r_cnt;
    w_data_nxt   = 1'b0;
    w_clk_en_nxt = 1'b0;
    w_done_nxt   = 1'b0;
    w_ovr_nxt    = r_ovr;
    unique case (r_state)
      ST_IDLE: begin
        w_done_nxt = 1'b1;
        if (i_packet_valid) begin
          w_state_nxt  = ST_SHIFT;
          w_shift_nxt  = i_packet_phase;
          w_cnt_nxt    = '0;
          w_data_nxt   = i_packet_phase[0];
          w_clk_en_nxt = 1'b1;
          w_done_nxt   = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (i_packet_valid) w_ovr_nxt = 1'b1;
        // r_cnt is the index of the bit currently on the wire.
        if (r_cnt == LAST_BIT) begin
          w_state_nxt = ST_GAP;
          w_shift_nxt = '0;
          w_cnt_nxt   = '0;
        end else begin
          w_shift_nxt  = r_shift >> 1;
          w_cnt_nxt    = r_cnt + 1'b1;
          w_data_nxt   = r_shift[1];
          w_clk_en_nxt = 1'b1;
        end
      end
      ST_GAP: begin
        if (i_packet_valid) w_ovr_nxt = 1'b1;
        if (r_cnt == LAST_GAP) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_shift_nxt = '0;
        w_cnt_nxt   = '0;
        w_done_nxt  = 1'b1;
      end
    endcase
  end

  assign o_ser_data = r_data;
  assign o_clk_en   = r_clk_en;
  assign o_ser_done = r_done;
  assign o_overrun  = r_ovr;

endmodule

// File: doc/sb_tx_serializer.md
SB_TX_SERIALIZER -- requirements
Module: sb_tx_serializer

Interface
REQ-001 The block SHALL have parameter PHASE_W, default 64, meaning the width of one framed packet phase in bits.
REQ-002 The block SHALL have parameter GAP_UI, default 32, meaning the number of mandatory low, clock-gated cycles after each phase (minimum 1).
REQ-003 The block SHALL have port i_clk, input, 1, the sideband serial clock; it is the only clock.
REQ-004 The block SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port i_packet_phase, input, PHASE_W, the framed phase from the packet framing stage.
REQ-006 The block SHALL have port i_packet_valid, input, 1, a single-cycle qualifier for i_packet_phase.
REQ-007 The block SHALL have port o_ser_data, output, 1, serial sideband data (TXDATASB), LSB first.
REQ-008 The block SHALL have port o_clk_en, output, 1, sideband clock enable (TXCKSB gating); high only while data bits are driven.
REQ-009 The block SHALL have port o_ser_done, output, 1, level ready-for-next-phase indication consumed by the framing stage.
REQ-010 The block SHALL have port o_overrun, output, 1, sticky error flag: a phase was offered while the block was busy.

Function
REQ-011 The block SHALL implement the FSM states IDLE, SHIFT and GAP; all outputs SHALL be registered.
REQ-012 In IDLE, o_ser_done SHALL be 1, o_ser_data SHALL be 0 and o_clk_en SHALL be 0.
REQ-013 IDLE with i_packet_valid=1 at a clock edge SHALL load the shift register with i_packet_phase, drive o_ser_data=i_packet_phase[0] and o_clk_en=1, clear o_ser_done, and enter SHIFT, all on that same edge.
REQ-014 In SHIFT, the block SHALL drive bits 0..PHASE_W-1 on PHASE_W consecutive cycles, one per cycle, LSB first, with o_clk_en=1 and o_ser_done=0.
REQ-015 The bit counter SHALL be sized to ceil(log2(max(PHASE_W,GAP_UI)))+1 bits and SHALL never wrap within a state.
REQ-016 After the cycle driving bit PHASE_W-1, the block SHALL enter GAP, with o_ser_data=0 and o_clk_en=0 for exactly GAP_UI cycles and o_ser_done=0.
REQ-017 At the end of the last GAP cycle, the block SHALL enter IDLE and set o_ser_done=1.
REQ-018 The total occupancy per phase SHALL be PHASE_W+GAP_UI cycles, measured from the load edge to the edge where o_ser_done reasserts (96 cycles at defaults).
REQ-019 Back-to-back operation: a valid arriving in the first IDLE cycle SHALL be accepted with no extra bubble, so the minimum phase period is PHASE_W+GAP_UI+1 cycles.
REQ-020 i_packet_valid=1 in SHIFT or GAP SHALL be ignored: the shift register is unchanged, o_overrun is set to 1 and stays set until reset, and the ongoing transfer completes unaffected.
REQ-021 i_packet_phase SHALL be don't-care whenever i_packet_valid=0.
REQ-022 The block SHALL perform no parity or header interpretation; the phase content is transmitted verbatim.

Reset
REQ-023 Asserting i_rst at any time, including mid-SHIFT or mid-GAP, SHALL immediately force IDLE: o_ser_data=0, o_clk_en=0, o_ser_done=1, o_overrun=0, shift register=0, counter=0.
REQ-024 The partially sent phase SHALL be discarded and not resumed after reset.
REQ-025 i_packet_valid=1 while i_rst=1 SHALL be ignored.
REQ-026 The first valid sampled after i_rst deasserts SHALL be accepted normally.

Verification
REQ-027 Single phase: load 64'hA5A5_0000_FFFF_1234 in IDLE -> o_ser_data carries bits 0..63 LSB first over 64 cycles with o_clk_en=1, then 32 cycles low with o_clk_en=0, then o_ser_done=1 at load edge +96.
REQ-028 Header+data pair: second valid presented on the first cycle o_ser_done=1 -> accepted on that edge, no idle bubble, o_overrun=0.
REQ-029 Overrun: valid pulsed at SHIFT cycle 10 with a different phase -> the first phase is transmitted intact and o_overrun=1 thereafter.
REQ-030 Reset mid-SHIFT at bit 40 -> the same cycle gives o_ser_data=0, o_clk_en=0, o_ser_done=1; the next valid is serialized from bit 0.
REQ-031 Boundary patterns: all-ones phase -> 64 cycles of 1 then exactly 32 zero cycles; all-zeros phase -> o_clk_en still high for exactly 64 cycles.
REQ-032 Parameter sweep: PHASE_W=8 with GAP_UI=1 -> occupancy of 9 cycles, with no counter wrap errors.
